// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared constants and field widths for the century clock counters
package clock_pkg;

   // Field widths
   localparam int D_W  = 5;
   localparam int M_W  = 4;
   localparam int WD_W = 3;

   // Range limits
   localparam logic [D_W-1:0]  D_MAX   = 5'd31;
   localparam logic [WD_W-1:0] WD_MAX  = 3'd6;
   localparam logic [M_W-1:0]  MON_FEB = 4'd2;

   // Weekday encoding, Sunday first
   localparam logic [WD_W-1:0] SUN = 3'd0;
   localparam logic [WD_W-1:0] MON = 3'd1;
   localparam logic [WD_W-1:0] TUE = 3'd2;
   localparam logic [WD_W-1:0] WED = 3'd3;
   localparam logic [WD_W-1:0] THU = 3'd4;
   localparam logic [WD_W-1:0] FRI = 3'd5;
   localparam logic [WD_W-1:0] SAT = 3'd6;

endpackage

// File: rtl/count_day_if.sv
// rtl/count_day_if.sv - strobe, date-load and count signals between count_day and its neighbours
interface count_day_if
   import clock_pkg::*;
#(
   parameter int Y_W = 7
);
   logic            pulse_d;
   logic [M_W-1:0]  cnt_mon;
   logic [Y_W-1:0]  cnt_y;
   logic            ld_en;
   logic [D_W-1:0]  ld_d;
   logic [WD_W-1:0] ld_wd;
   logic [D_W-1:0]  cnt_d;
   logic [WD_W-1:0] cnt_wd;
   logic            pulse_mon;

   // Upstream side: hour counter, month/year counters and set logic
   modport master (
      output pulse_d, cnt_mon, cnt_y, ld_en, ld_d, ld_wd,
      input  cnt_d, cnt_wd, pulse_mon
   );

   // The day counter itself
   modport slave (
      input  pulse_d, cnt_mon, cnt_y, ld_en, ld_d, ld_wd,
      output cnt_d, cnt_wd, pulse_mon
   );
endinterface

// File: rtl/days_in_month.sv
// rtl/days_in_month.sv - combinational month length from month number and year-within-century
module days_in_month
   import clock_pkg::*;
(
   input  logic [M_W-1:0] mon_i,
   input  logic [1:0]     yl_i,
   output logic [D_W-1:0] dim_o
);

   // Month length lookup; every year divisible by 4 in 2000..2099 is leap, and
   // illegal month codes fall back to the longest month so nothing is clamped.
   always_comb begin
      dim_o = D_MAX;
      case (mon_i)
         4'd4, 4'd6, 4'd9, 4'd11: dim_o = 5'd30;
         MON_FEB:                 dim_o = (yl_i == 2'd0) ? 5'd29 : 5'd28;
         default:                 dim_o = D_MAX;
      endcase
   end

endmodule

// File: rtl/count_day.sv
// rtl/count_day.sv - day-of-month and day-of-week counter with month-end pulse and date load
module count_day
   import clock_pkg::*;
#(
   parameter logic [WD_W-1:0] WD_RST = 3'd6,
   parameter int              Y_W    = 7
)(
   input  logic        clk,
   input  logic        set_day,
   count_day_if.slave  bus
);

   logic [D_W-1:0]  dim;
   logic [D_W-1:0]  cnt_d_q,  cnt_d_d;
   logic [WD_W-1:0] cnt_wd_q, cnt_wd_d;
   logic            pulse_mon_q, pulse_mon_d;

   // Only the low two year bits matter for leap years inside one century
   logic unused_year_bits;
   assign unused_year_bits = ^bus.cnt_y[Y_W-1:2];

   days_in_month u_dim (
      .mon_i (bus.cnt_mon),
      .yl_i  (bus.cnt_y[1:0]),
      .dim_o (dim)
   );

   // Priority mux: load beats strobe, strobe beats clamp, otherwise hold
   always_comb begin
      cnt_d_d     = cnt_d_q;
      cnt_wd_d    = cnt_wd_q;
      pulse_mon_d = 1'b0;
      if (bus.ld_en) begin
         if (bus.ld_d == '0)
            cnt_d_d = 5'd1;
         else if (bus.ld_d > dim)
            cnt_d_d = dim;
         else
            cnt_d_d = bus.ld_d;
         cnt_wd_d = (bus.ld_wd == 3'd7) ? SUN : bus.ld_wd;
      end else if (bus.pulse_d) begin
         if (cnt_d_q >= dim) begin
            cnt_d_d     = 5'd1;
            pulse_mon_d = 1'b1;
         end else begin
            cnt_d_d = cnt_d_q + 5'd1;
         end
         cnt_wd_d = (cnt_wd_q >= WD_MAX) ? SUN : cnt_wd_q + 3'd1;
      end else if (cnt_d_q > dim) begin
         // Month shortened under us (e.g. set to Feb while on the 31st)
         cnt_d_d = dim;
      end
   end

   // State registers with synchronous active-low reset overriding everything
   always_ff @(posedge clk) begin
      if (!set_day) begin
         cnt_d_q     <= 5'd1;
         cnt_wd_q    <= WD_RST;
         pulse_mon_q <= 1'b0;
      end else begin
         cnt_d_q     <= cnt_d_d;
         cnt_wd_q    <= cnt_wd_d;
         pulse_mon_q <= pulse_mon_d;
      end
   end

   assign bus.cnt_d     = cnt_d_q;
   assign bus.cnt_wd    = cnt_wd_q;
   assign bus.pulse_mon = pulse_mon_q;

endmodule

// File: tb/tb_count_day.sv
// tb/tb_count_day.sv - directed self-checking bench for count_day
module tb_count_day;

   logic clk;
   logic set_day;
   int   n_run;
   int   n_fail;

   count_day_if #(.Y_W(7)) bus ();

   count_day #(.WD_RST(3'd6), .Y_W(7)) dut (
      .clk     (clk),
      .set_day (set_day),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge and settle past it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a one-cycle load
   task automatic do_load(input logic [4:0] d, input logic [2:0] wd);
      bus.ld_d  = d;
      bus.ld_wd = wd;
      bus.ld_en = 1'b1;
      tick();
      bus.ld_en = 1'b0;
   endtask

   // Drive a one-cycle day strobe
   task automatic do_pulse();
      bus.pulse_d = 1'b1;
      tick();
      bus.pulse_d = 1'b0;
   endtask

   task automatic test_reset();
      set_day = 1'b0;
      tick();
      tick();
      set_day = 1'b1;
      n_run++;
      if ({bus.cnt_d, bus.cnt_wd, bus.pulse_mon} !== {5'd1, 3'd6, 1'b0}) begin
         n_fail++;
         $display("FAIL reset: d=%0d wd=%0d pm=%0b, expected d=1 wd=6 pm=0", bus.cnt_d, bus.cnt_wd, bus.pulse_mon);
      end
      tick();
      n_run++;
      if ({bus.cnt_d, bus.cnt_wd, bus.pulse_mon} !== {5'd1, 3'd6, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_hold: d=%0d wd=%0d pm=%0b, expected d=1 wd=6 pm=0", bus.cnt_d, bus.cnt_wd, bus.pulse_mon);
      end
   endtask

   task automatic test_month_end();
      bus.cnt_mon = 4'd1;
      bus.cnt_y   = 7'd0;
      do_load(5'd31, 3'd6);
      n_run++;
      if ({bus.cnt_d, bus.cnt_wd, bus.pulse_mon} !== {5'd31, 3'd6, 1'b0}) begin
         n_fail++;
         $display("FAIL jan_load: d=%0d wd=%0d pm=%0b, expected d=31 wd=6 pm=0", bus.cnt_d, bus.cnt_wd, bus.pulse_mon);
      end
      do_pulse();
      n_run++;
      if ({bus.cnt_d, bus.cnt_wd, bus.pulse_mon} !== {5'd1, 3'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL jan_end: d=%0d wd=%0d pm=%0b, expected d=1 wd=0 pm=1", bus.cnt_d, bus.cnt_wd, bus.pulse_mon);
      end
      tick();
      n_run++;
      if ({bus.cnt_d, bus.cnt_wd, bus.pulse_mon} !== {5'd1, 3'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL pm_width: d=%0d wd=%0d pm=%0b, expected d=1 wd=0 pm=0", bus.cnt_d, bus.cnt_wd, bus.pulse_mon);
      end
   endtask

   task automatic test_feb();
      bus.cnt_mon = 4'd2;
      bus.cnt_y   = 7'd23;
      do_load(5'd28, 3'd0);
      do_pulse();
      n_run++;
      if ({bus.cnt_d, bus.cnt_wd, bus.pulse_mon} !== {5'd1, 3'd1, 1'b1}) begin
         n_fail++;
         $display("FAIL feb23_end: d=%0d wd=%0d pm=%0b, expected d=1 wd=1 pm=1", bus.cnt_d, bus.cnt_wd, bus.pulse_mon);
      end
      bus.cnt_y = 7'd24;
      do_load(5'd28, 3'd0);
      do_pulse();
      n_run++;
      if ({bus.cnt_d, bus.cnt_wd, bus.pulse_mon} !== {5'd29, 3'd1, 1'b0}) begin
         n_fail++;
         $display("FAIL feb24_29: d=%0d wd=%0d pm=%0b, expected d=29 wd=1 pm=0", bus.cnt_d, bus.cnt_wd, bus.pulse_mon);
      end
      do_pulse();
      n_run++;
      if ({bus.cnt_d, bus.cnt_wd, bus.pulse_mon} !== {5'd1, 3'd2, 1'b1}) begin
         n_fail++;
         $display("FAIL feb24_end: d=%0d wd=%0d pm=%0b, expected d=1 wd=2 pm=1", bus.cnt_d, bus.cnt_wd, bus.pulse_mon);
      end
      bus.cnt_y = 7'd0;
      do_load(5'd31, 3'd4);
      n_run++;
      if ({bus.cnt_d, bus.cnt_wd, bus.pulse_mon} !== {5'd29, 3'd4, 1'b0}) begin
         n_fail++;
         $display("FAIL feb00_leap: d=%0d wd=%0d pm=%0b, expected d=29 wd=4 pm=0", bus.cnt_d, bus.cnt_wd, bus.pulse_mon);
      end
   endtask

   task automatic test_30_day();
      bus.cnt_mon = 4'd4;
      bus.cnt_y   = 7'd25;
      do_load(5'd30, 3'd3);
      do_pulse();
      n_run++;
      if ({bus.cnt_d, bus.cnt_wd, bus.pulse_mon} !== {5'd1, 3'd4, 1'b1}) begin
         n_fail++;
         $display("FAIL apr_end: d=%0d wd=%0d pm=%0b, expected d=1 wd=4 pm=1", bus.cnt_d, bus.cnt_wd, bus.pulse_mon);
      end
      do_load(5'd29, 3'd3);
      do_pulse();
      n_run++;
      if ({bus.cnt_d, bus.cnt_wd, bus.pulse_mon} !== {5'd30, 3'd4, 1'b0}) begin
         n_fail++;
         $display("FAIL apr_29: d=%0d wd=%0d pm=%0b, expected d=30 wd=4 pm=0", bus.cnt_d, bus.cnt_wd, bus.pulse_mon);
      end
   endtask

   task automatic test_load_clamp();
      bus.cnt_mon = 4'd2;
      bus.cnt_y   = 7'd25;
      do_load(5'd31, 3'd2);
      n_run++;
      if ({bus.cnt_d, bus.cnt_wd, bus.pulse_mon} !== {5'd28, 3'd2, 1'b0}) begin
         n_fail++;
         $display("FAIL load_hi: d=%0d wd=%0d pm=%0b, expected d=28 wd=2 pm=0", bus.cnt_d, bus.cnt_wd, bus.pulse_mon);
      end
      do_load(5'd0, 3'd7);
      n_run++;
      if ({bus.cnt_d, bus.cnt_wd, bus.pulse_mon} !== {5'd1, 3'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL load_zero: d=%0d wd=%0d pm=%0b, expected d=1 wd=0 pm=0", bus.cnt_d, bus.cnt_wd, bus.pulse_mon);
      end
      bus.cnt_mon = 4'd1;
      do_load(5'd31, 3'd5);
      bus.pulse_d = 1'b1;
      do_load(5'd15, 3'd3);
      bus.pulse_d = 1'b0;
      n_run++;
      if ({bus.cnt_d, bus.cnt_wd, bus.pulse_mon} !== {5'd15, 3'd3, 1'b0}) begin
         n_fail++;
         $display("FAIL load_vs_pulse: d=%0d wd=%0d pm=%0b, expected d=15 wd=3 pm=0", bus.cnt_d, bus.cnt_wd, bus.pulse_mon);
      end
      do_load(5'd31, 3'd5);
      bus.cnt_mon = 4'd6;
      tick();
      n_run++;
      if ({bus.cnt_d, bus.cnt_wd, bus.pulse_mon} !== {5'd30, 3'd5, 1'b0}) begin
         n_fail++;
         $display("FAIL clamp_jun: d=%0d wd=%0d pm=%0b, expected d=30 wd=5 pm=0", bus.cnt_d, bus.cnt_wd, bus.pulse_mon);
      end
      bus.cnt_mon = 4'd2;
      tick();
      n_run++;
      if ({bus.cnt_d, bus.cnt_wd, bus.pulse_mon} !== {5'd28, 3'd5, 1'b0}) begin
         n_fail++;
         $display("FAIL clamp_feb: d=%0d wd=%0d pm=%0b, expected d=28 wd=5 pm=0", bus.cnt_d, bus.cnt_wd, bus.pulse_mon);
      end
   endtask

   task automatic test_back_to_back();
      bus.cnt_mon = 4'd1;
      do_load(5'd30, 3'd5);
      bus.pulse_d = 1'b1;
      tick();
      n_run++;
      if ({bus.cnt_d, bus.cnt_wd, bus.pulse_mon} !== {5'd31, 3'd6, 1'b0}) begin
         n_fail++;
         $display("FAIL b2b_1: d=%0d wd=%0d pm=%0b, expected d=31 wd=6 pm=0", bus.cnt_d, bus.cnt_wd, bus.pulse_mon);
      end
      tick();
      n_run++;
      if ({bus.cnt_d, bus.cnt_wd, bus.pulse_mon} !== {5'd1, 3'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL b2b_2: d=%0d wd=%0d pm=%0b, expected d=1 wd=0 pm=1", bus.cnt_d, bus.cnt_wd, bus.pulse_mon);
      end
      tick();
      bus.pulse_d = 1'b0;
      n_run++;
      if ({bus.cnt_d, bus.cnt_wd, bus.pulse_mon} !== {5'd2, 3'd1, 1'b0}) begin
         n_fail++;
         $display("FAIL b2b_3: d=%0d wd=%0d pm=%0b, expected d=2 wd=1 pm=0", bus.cnt_d, bus.cnt_wd, bus.pulse_mon);
      end
   endtask

   task automatic test_illegal_mon();
      bus.cnt_mon = 4'd0;
      do_load(5'd31, 3'd1);
      n_run++;
      if ({bus.cnt_d, bus.cnt_wd, bus.pulse_mon} !== {5'd31, 3'd1, 1'b0}) begin
         n_fail++;
         $display("FAIL mon0_load: d=%0d wd=%0d pm=%0b, expected d=31 wd=1 pm=0", bus.cnt_d, bus.cnt_wd, bus.pulse_mon);
      end
      bus.cnt_mon = 4'd13;
      do_pulse();
      n_run++;
      if ({bus.cnt_d, bus.cnt_wd, bus.pulse_mon} !== {5'd1, 3'd2, 1'b1}) begin
         n_fail++;
         $display("FAIL mon13_end: d=%0d wd=%0d pm=%0b, expected d=1 wd=2 pm=1", bus.cnt_d, bus.cnt_wd, bus.pulse_mon);
      end
   endtask

   task automatic test_midop_reset();
      bus.cnt_mon = 4'd1;
      do_load(5'd31, 3'd2);
      set_day     = 1'b0;
      bus.pulse_d = 1'b1;
      tick();
      bus.pulse_d = 1'b0;
      set_day     = 1'b1;
      n_run++;
      if ({bus.cnt_d, bus.cnt_wd, bus.pulse_mon} !== {5'd1, 3'd6, 1'b0}) begin
         n_fail++;
         $display("FAIL midop_reset: d=%0d wd=%0d pm=%0b, expected d=1 wd=6 pm=0", bus.cnt_d, bus.cnt_wd, bus.pulse_mon);
      end
      tick();
      n_run++;
      if ({bus.cnt_d, bus.cnt_wd, bus.pulse_mon} !== {5'd1, 3'd6, 1'b0}) begin
         n_fail++;
         $display("FAIL midop_after: d=%0d wd=%0d pm=%0b, expected d=1 wd=6 pm=0", bus.cnt_d, bus.cnt_wd, bus.pulse_mon);
      end
   endtask

   initial begin
      n_run       = 0;
      n_fail      = 0;
      set_day     = 1'b0;
      bus.pulse_d = 1'b0;
      bus.cnt_mon = 4'd1;
      bus.cnt_y   = 7'd0;
      bus.ld_en   = 1'b0;
      bus.ld_d    = 5'd0;
      bus.ld_wd   = 3'd0;
      test_reset();
      test_month_end();
      test_feb();
      test_30_day();
      test_load_clamp();
      test_back_to_back();
      test_illegal_mon();
      test_midop_reset();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
